i2c_target_regif: RTL
=====================

// Module: i2c_target_regif
// PURPOSE
//  I2C target (slave) responder for the i2c_mux host path; the opposite end of i2c_master_ctrl on the shared SCL/SDA bus.
//  Decodes START/STOP, matches a 7-bit address, captures an offset byte, then accepts write bytes or serves read bytes.
//  Presents a byte-wide register interface (offset, data, strobes) to local logic. No clock stretching; SCL is input only.
// PARAMETERS
//  SLAVE_ADDR   7'h23  7-bit target address (write byte 8'h46, read byte 8'h47).
//  FILTER_LEN   3      SYSTEM_CLK cycles a synced SCL/SDA level must hold before it is accepted (glitch filter, >=1).
//  AUTO_INC     1      1: offset increments after every data byte, 8'hFF wraps to 8'h00; 0: offset held.
// PORTS
//  SYSTEM_CLK  in     1  system clock, all logic on rising edge.
//  RESET       in     1  asynchronous, active-high reset.
//  SCL         in     1  I2C clock from bus (external pullup).
//  SDA         inout  1  I2C data; driven 1'b0 or 1'bz only (open drain).
//  tx_data     in     8  read byte from local logic, sampled as described below.
//  rx_address  out    8  last matched address byte incl. R/W bit.
//  rx_offset   out    8  current register offset.
//  rx_data     out    8  last written data byte.
//  owrite_en   out    1  1-cycle strobe: rx_offset/rx_data valid for a write.
//  oread_en    out    1  1-cycle strobe: local logic must present tx_data for rx_offset.
//  obusy       out    1  high from matched address ACK until STOP/Sr/NACK/mismatch.
// BEHAVIOUR
//  Reset: rx_* = 8'h00, owrite_en = oread_en = obusy = 0, SDA = z, FSM = IDLE; effective immediately (async), mid-transfer included.
//  Input path: 2-FF synchronizer then FILTER_LEN filter on SCL and SDA; edges derived from filtered levels (latency 2+FILTER_LEN clk).
//  START: SDA falls while SCL high; STOP: SDA rises while SCL high. Both detected in every state; START in any state -> ADDR
//   (repeated start), STOP in any state -> IDLE with SDA released. Offset is kept across Sr.
//  Data bits sampled on filtered SCL rising edge, MSB first; SDA output changes only on filtered SCL falling edge.
//  FSM: IDLE -> ADDR (8 bits) -> ADDR_ACK -> {OFFSET | RDATA}; OFFSET -> OFF_ACK -> WDATA -> WD_ACK -> WDATA ...;
//   RDATA -> M_ACK -> RDATA (master ACK) or IDLE (master NACK).
//  ADDR: addr[7:1] != SLAVE_ADDR -> IDLE, SDA never driven, no strobes, rx_address unchanged.
//  ACK drive: SDA=0 from the SCL fall ending bit 8 to the SCL fall ending the ACK bit (ADDR_ACK, OFF_ACK, WD_ACK); released after.
//  Write (R/W=0): first byte after address -> rx_offset. Each following byte -> rx_data, owrite_en pulses 1 clk at the SCL rise
//   of bit 8, with rx_offset = target offset; after the ACK, rx_offset += AUTO_INC (8-bit wrap).
//  Read (R/W=1): oread_en pulses 1 clk at the SCL rise of the ADDR_ACK bit and of each M_ACK bit sampled as ACK;
//   tx_data latched on the next SCL fall and shifted out MSB first (bit=0 -> drive 0, bit=1 -> z).
//   rx_offset increments (AUTO_INC) at each M_ACK rise, before that oread_en. No oread_en after NACK.
//  Write without offset byte (STOP right after ADDR_ACK): no strobe, offset unchanged.
//  Simultaneous STOP/START with a pending strobe: strobe for a fully received byte still issued; partial bytes discarded.
//  Bus never driven in IDLE or ADDR; SDA released within one clk of STOP detection.
// STRUCTURE
//  Package i2c_pkg: FSM state encoding, I2C_ACK/I2C_NACK constants, 7-bit address width, bit-counter width.
//  Sub-module i2c_bus_filter (sync + glitch filter + rise/fall/START/STOP pulses), instanced once per SCL/SDA pair;
//   top holds FSM, shift register, bit counter, offset counter, SDA open-drain driver.
// TESTING  (SYSTEM_CLK 25 MHz, SCL 100 kHz, pullups on SCL/SDA)
//  Write: S 8'h46 8'h5A 8'h3C P -> ACK x3, owrite_en once, rx_offset=8'h5A, rx_data=8'h3C, rx_address=8'h46, obusy low after P.
//  Read: S 46 5A Sr 47, tx_data=8'hA0, master NACK, P -> oread_en once at offset 8'h5A, SDA bits 1010_0000, released after NACK.
//  Burst: S 46 FF 11 22 P -> owrite_en x2 with (FF,11),(00,22); burst read with 2 ACKs + NACK -> 3 oread_en at 00,01,02.
//  Mismatch: S 8'h48 ... P -> no ACK (SDA stays z/1), no strobes, rx_* unchanged.
//  Glitch: 1-clk SDA low pulse while SCL high and 1-clk SCL pulse -> no START/bit detected, state unchanged.
//  Reset mid-read (SDA driven 0): assert RESET -> SDA z in same cycle, all outputs zero; next S 46 .. transfer completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register interface.
`timescale 1ns/1ps
package i2c_pkg;
   localparam int ADDR_W   = 7;
   localparam int BITCNT_W = 4;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_OFFSET,
      ST_OFF_ACK,
      ST_WDATA,
      ST_WD_ACK,
      ST_RDATA,
      ST_M_ACK
   } i2c_state_e;
endpackage

// File: rtl/i2c_bus_filter.sv
// Synchronizes and glitch-filters SCL/SDA, then derives SCL edges and START/STOP pulses.
`timescale 1ns/1ps
module i2c_bus_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic scl,
   input  logic sda,
   output logic sda_f,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);
   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   // Bit 0 carries SCL, bit 1 carries SDA; idle bus level is high.
   logic [1:0]            sync_p0, sync_p1, filt_p2, filt_p3;
   logic [1:0][CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= 2'b11;
         sync_p1 <= 2'b11;
         filt_p2 <= 2'b11;
         filt_p3 <= 2'b11;
         cnt     <= '0;
      end else begin
         sync_p0 <= {sda, scl};
         sync_p1 <= sync_p0;
         filt_p3 <= filt_p2;
         for (int i = 0; i < 2; i++) begin
            if (sync_p1[i] == filt_p2[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_W'(FILTER_LEN - 1)) begin
               filt_p2[i] <= sync_p1[i];
               cnt[i]     <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign sda_f     = filt_p2[1];
   assign scl_rise  = filt_p2[0] & ~filt_p3[0];
   assign scl_fall  = ~filt_p2[0] & filt_p3[0];
   assign start_det = filt_p2[0] & filt_p3[0] & filt_p3[1] & ~filt_p2[1];
   assign stop_det  = filt_p2[0] & filt_p3[0] & ~filt_p3[1] & filt_p2[1];
endmodule

// File: rtl/i2c_target_regif.sv
// I2C target: address match, offset capture, byte writes and reads onto a local register port.
`timescale 1ns/1ps
module i2c_target_regif
   import i2c_pkg::*;
#(
   parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h23,
   parameter int                FILTER_LEN = 3,
   parameter int                AUTO_INC   = 1
) (
   input  logic       SYSTEM_CLK,
   input  logic       RESET,
   input  logic       SCL,
   inout  wire        SDA,
   input  logic [7:0] tx_data,
   output logic [7:0] rx_address,
   output logic [7:0] rx_offset,
   output logic [7:0] rx_data,
   output logic       owrite_en,
   output logic       oread_en,
   output logic       obusy
);
   localparam logic [7:0] OFF_STEP = (AUTO_INC != 0) ? 8'd1 : 8'd0;

   i2c_state_e          state, state_nx;
   logic                sda_f, scl_rise, scl_fall, start_det, stop_det;
   logic                bus_evt, last_rise, last_fall, addr_match, m_ack;
   logic [BITCNT_W-1:0] bit_cnt;
   logic [7:0]          shift_reg, rx_byte;
   logic [6:0]          tx_sh;
   logic                sda_low;

   i2c_bus_filter #(.FILTER_LEN(FILTER_LEN)) u_bus_filter (
      .clk       (SYSTEM_CLK),
      .rst       (RESET),
      .scl       (SCL),
      .sda       (SDA),
      .sda_f     (sda_f),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   assign SDA        = sda_low ? 1'b0 : 1'bz;
   assign bus_evt    = start_det | stop_det;
   assign rx_byte    = {shift_reg[6:0], sda_f};
   assign last_rise  = scl_rise && (bit_cnt == BITCNT_W'(7));
   assign last_fall  = scl_fall && (bit_cnt == BITCNT_W'(8));
   assign addr_match = (shift_reg[7:1] == SLAVE_ADDR);
   assign m_ack      = (sda_f == I2C_ACK);
   assign obusy      = (state != ST_IDLE) && (state != ST_ADDR);

   always_ff @(posedge SYSTEM_CLK or posedge RESET) begin
      if (RESET) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (stop_det) begin
         state_nx = ST_IDLE;
      end else if (start_det) begin
         state_nx = ST_ADDR;
      end else begin
         case (state)
            ST_ADDR:     if (last_fall) state_nx = addr_match ? ST_ADDR_ACK : ST_IDLE;
            ST_ADDR_ACK: if (scl_fall)  state_nx = rx_address[0] ? ST_RDATA : ST_OFFSET;
            ST_OFFSET:   if (last_fall) state_nx = ST_OFF_ACK;
            ST_OFF_ACK:  if (scl_fall)  state_nx = ST_WDATA;
            ST_WDATA:    if (last_fall) state_nx = ST_WD_ACK;
            ST_WD_ACK:   if (scl_fall)  state_nx = ST_WDATA;
            ST_RDATA:    if (last_fall) state_nx = ST_M_ACK;
            ST_M_ACK: begin
               if (scl_rise && !m_ack) state_nx = ST_IDLE;
               else if (scl_fall)      state_nx = ST_RDATA;
            end
            default:     state_nx = state;
         endcase
      end
   end

   // Byte shifters carry no reset: every use is preceded by a full load.
   always_ff @(posedge SYSTEM_CLK) begin
      if (scl_rise && (state == ST_ADDR || state == ST_OFFSET || state == ST_WDATA))
         shift_reg <= rx_byte;
      if (scl_fall) begin
         if ((state == ST_ADDR_ACK && rx_address[0]) || state == ST_M_ACK)
            tx_sh <= tx_data[6:0];
         else if (state == ST_RDATA)
            tx_sh <= {tx_sh[5:0], 1'b0};
      end
   end

   always_ff @(posedge SYSTEM_CLK or posedge RESET) begin
      if (RESET) begin
         bit_cnt    <= '0;
         sda_low    <= 1'b0;
         rx_address <= 8'h00;
         rx_offset  <= 8'h00;
         rx_data    <= 8'h00;
         owrite_en  <= 1'b0;
         oread_en   <= 1'b0;
      end else begin
         owrite_en <= 1'b0;
         oread_en  <= 1'b0;

         if (bus_evt || state_nx != state) bit_cnt <= '0;
         else if (scl_rise)                bit_cnt <= bit_cnt + 1'b1;

         // SDA only moves on SCL fall; START/STOP always let go of the bus.
         if (bus_evt) begin
            sda_low <= 1'b0;
         end else if (scl_fall) begin
            case (state)
               ST_ADDR:             sda_low <= (bit_cnt == BITCNT_W'(8)) && addr_match;
               ST_OFFSET, ST_WDATA: sda_low <= (bit_cnt == BITCNT_W'(8));
               ST_ADDR_ACK:         sda_low <= rx_address[0] & ~tx_data[7];
               ST_RDATA:            sda_low <= (bit_cnt != BITCNT_W'(8)) & ~tx_sh[6];
               ST_M_ACK:            sda_low <= ~tx_data[7];
               default:             sda_low <= 1'b0;
            endcase
         end

         if (state == ST_ADDR && last_fall && addr_match) rx_address <= shift_reg;
         if (state == ST_OFFSET && last_rise) rx_offset <= rx_byte;
         if (state == ST_WDATA && last_rise) begin
            rx_data   <= rx_byte;
            owrite_en <= 1'b1;
         end
         if (state == ST_WD_ACK && scl_fall) rx_offset <= rx_offset + OFF_STEP;
         if (state == ST_ADDR_ACK && scl_rise && rx_address[0]) oread_en <= 1'b1;
         if (state == ST_M_ACK && scl_rise && m_ack) begin
            rx_offset <= rx_offset + OFF_STEP;
            oread_en  <= 1'b1;
         end
      end
   end
endmodule
